// File: rtl/insn_retire_monitor.sv
// Run monitor for the single-cycle core: counts cycles and retirements,
// samples the PC periodically and flags PASS (self-loop halt) or FAIL (timeout).
module insn_retire_monitor #(
  parameter int PC_W           = 32,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 2000,
  parameter int HALT_REPEAT    = 8,
  parameter int SAMPLE_PERIOD  = 100
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic [PC_W-1:0]  i_pc_debug,
  input  logic             i_insn_vld,
  output logic [1:0]       o_state,
  output logic             o_pass,
  output logic             o_fail,
  output logic [CNT_W-1:0] o_cycles,
  output logic [CNT_W-1:0] o_retired,
  output logic [PC_W-1:0]  o_halt_pc,
  output logic             o_sample_vld,
  output logic [PC_W-1:0]  o_sample_pc
);

  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(HALT_REPEAT + 1);
  localparam int SW = $clog2(SAMPLE_PERIOD + 1);

  localparam logic [IW-1:0] TO_LIM = IW'(TIMEOUT_CYCLES);
  localparam logic [RW-1:0] HR_LIM = RW'(HALT_REPEAT);
  localparam logic [SW-1:0] SP_TOP = SW'(SAMPLE_PERIOD - 1);

  typedef enum logic [1:0] {
    S_WAIT    = 2'b00,
    S_RUN     = 2'b01,
    S_HALT    = 2'b10,
    S_TIMEOUT = 2'b11
  } state_t;

  state_t            r_state;
  logic [IW-1:0]     r_idle_cnt;
  logic [RW-1:0]     r_rep_cnt;
  logic [PC_W-1:0]   r_last_pc;
  logic [SW-1:0]     r_samp_cnt;
  logic              r_pass;
  logic              r_fail;
  logic [CNT_W-1:0]  r_cycles;
  logic [CNT_W-1:0]  r_retired;
  logic [PC_W-1:0]   r_halt_pc;
  logic              r_sample_vld;
  logic [PC_W-1:0]   r_sample_pc;

  logic              w_active;
  logic              w_same;
  logic [IW-1:0]     w_idle_nxt;
  logic [RW-1:0]     w_rep_nxt;
  logic              w_timeout;
  logic              w_halt;

  always_comb begin
    w_active   = (r_state == S_WAIT) || (r_state == S_RUN);
    // WAIT means nothing has retired yet, so no run is in progress
    w_same     = (r_state == S_RUN) && (i_pc_debug == r_last_pc);
    w_idle_nxt = i_insn_vld ? '0 : r_idle_cnt + IW'(1);
    w_rep_nxt  = w_same ? r_rep_cnt + RW'(1) : RW'(1);
    w_timeout  = w_active && !i_insn_vld && (w_idle_nxt == TO_LIM);
    w_halt     = (r_state == S_RUN) && i_insn_vld && (w_rep_nxt == HR_LIM);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_WAIT;
      r_idle_cnt   <= '0;
      r_rep_cnt    <= '0;
      r_last_pc    <= '0;
      r_samp_cnt   <= '0;
      r_pass       <= 1'b0;
      r_fail       <= 1'b0;
      r_cycles     <= '0;
      r_retired    <= '0;
      r_halt_pc    <= '0;
      r_sample_vld <= 1'b0;
      r_sample_pc  <= '0;
    end else if (i_clear) begin
      r_state      <= S_WAIT;
      r_idle_cnt   <= '0;
      r_rep_cnt    <= '0;
      r_last_pc    <= '0;
      r_samp_cnt   <= '0;
      r_pass       <= 1'b0;
      r_fail       <= 1'b0;
      r_cycles     <= '0;
      r_retired    <= '0;
      r_halt_pc    <= '0;
      r_sample_vld <= 1'b0;
      r_sample_pc  <= '0;
    end else if (w_active) begin
      if (r_cycles != '1) r_cycles <= r_cycles + CNT_W'(1);
      r_idle_cnt <= w_idle_nxt;
      if (i_insn_vld) begin
        if (r_retired != '1) r_retired <= r_retired + CNT_W'(1);
        r_rep_cnt <= w_rep_nxt;
        r_last_pc <= i_pc_debug;
      end
      if (r_samp_cnt == SP_TOP) begin
        r_samp_cnt   <= '0;
        r_sample_vld <= 1'b1;
        r_sample_pc  <= i_pc_debug;
      end else begin
        r_samp_cnt   <= r_samp_cnt + SW'(1);
        r_sample_vld <= 1'b0;
      end
      if (w_timeout) begin
        r_state <= S_TIMEOUT;
        r_fail  <= 1'b1;
      end else if (w_halt) begin
        r_state   <= S_HALT;
        r_pass    <= 1'b1;
        r_halt_pc <= i_pc_debug;
      end else if (i_insn_vld && r_state == S_WAIT) begin
        r_state <= S_RUN;
      end
    end else begin
      r_sample_vld <= 1'b0;
    end
  end

  assign o_state      = r_state;
  assign o_pass       = r_pass;
  assign o_fail       = r_fail;
  assign o_cycles     = r_cycles;
  assign o_retired    = r_retired;
  assign o_halt_pc    = r_halt_pc;
  assign o_sample_vld = r_sample_vld;
  assign o_sample_pc  = r_sample_pc;

endmodule

// File: tb/tb_insn_retire_monitor.sv
// Directed bench for insn_retire_monitor: timeout, halt, sampling,
// clear/reset and counter saturation (second instance with CNT_W=4).
module tb_insn_retire_monitor;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic [31:0] pc;
  logic        vld;

  logic [1:0]  st;
  logic        pass, fail;
  logic [31:0] cycles, retired, halt_pc, spc;
  logic        svld;

  logic [1:0]  st4;
  logic        pass4, fail4;
  logic [3:0]  cycles4, retired4;
  logic [31:0] halt_pc4, spc4;
  logic        svld4;

  int checks = 0;
  int errors = 0;
  int pulses;

  insn_retire_monitor dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clr),
    .i_pc_debug(pc), .i_insn_vld(vld),
    .o_state(st), .o_pass(pass), .o_fail(fail),
    .o_cycles(cycles), .o_retired(retired),
    .o_halt_pc(halt_pc), .o_sample_vld(svld),
    .o_sample_pc(spc)
  );

  insn_retire_monitor #(.CNT_W(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clr),
    .i_pc_debug(pc), .i_insn_vld(vld),
    .o_state(st4), .o_pass(pass4), .o_fail(fail4),
    .o_cycles(cycles4), .o_retired(retired4),
    .o_halt_pc(halt_pc4), .o_sample_vld(svld4),
    .o_sample_pc(spc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr   = 1'b0;
    vld   = 1'b0;
    pc    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // 1: never retire -> timeout at edge 2000
    do_reset();
    check("rst_state", st, 0);
    check("rst_outs", {pass, fail, svld}, 0);
    check("rst_cnts", {cycles, retired}, 0);
    check("rst_pcs", {halt_pc, spc}, 0);
    repeat (1999) step();
    check("t1_pre_state", st, 0);
    check("t1_pre_fail", fail, 0);
    step();
    check("t1_state", st, 3);
    check("t1_fail", fail, 1);
    check("t1_pass", pass, 0);
    check("t1_cycles", cycles, 2000);
    check("t1_retired", retired, 0);
    repeat (5) step();
    check("t1_frozen", cycles, 2000);
    check("t1_sticky", {st, fail}, {2'd3, 1'b1});

    // 2: ramp 50 then self-loop at 0x40
    do_reset();
    vld = 1'b1;
    for (int k = 0; k < 50; k++) begin
      pc = 32'(4 * k);
      step();
    end
    check("t2_run", st, 1);
    pc = 32'h40;
    repeat (7) step();
    check("t2_pre_halt", {st, pass}, {2'd1, 1'b0});
    step();
    check("t2_state", st, 2);
    check("t2_pass", pass, 1);
    check("t2_halt_pc", halt_pc, 32'h40);
    check("t2_retired", retired, 58);
    check("t2_cycles", cycles, 58);
    pc = 32'h100;
    repeat (10) step();
    check("t2_frz_ret", retired, 58);
    check("t2_frz_cyc", cycles, 58);
    check("t2_frz_st", {st, pass, fail}, {2'd2, 1'b1, 1'b0});

    // 3: valid pulses 1999 idle apart, then a 2000-cycle gap
    do_reset();
    for (int k = 0; k < 3; k++) begin
      vld = 1'b1;
      pc  = 32'(16 + 4 * k);
      step();
      vld = 1'b0;
      repeat (1999) step();
    end
    check("t3_no_fail", {st, fail}, {2'd1, 1'b0});
    check("t3_retired", retired, 3);
    step();
    check("t3_fail", fail, 1);
    check("t3_state", st, 3);

    // 4a: sample pulses on a PC ramp
    do_reset();
    vld = 1'b1;
    pulses = 0;
    for (int e = 1; e <= 300; e++) begin
      pc = 32'(4 * (e - 1));
      step();
      if (svld) pulses++;
      if (e % 100 == 0) begin
        check($sformatf("t4_svld_%0d", e), svld, 1);
        check($sformatf("t4_spc_%0d", e), spc, 32'(4 * (e - 1)));
      end
      if (e == 101) check("t4_after", svld, 0);
      if (e == 150) check("t4_hold", spc, 396);
    end
    check("t4_pulses", pulses, 3);
    check("t4_retired", retired, 300);

    // 4b: an invalid cycle does not break a same-PC run
    do_reset();
    pc  = 32'h80;
    vld = 1'b1;
    repeat (4) step();
    vld = 1'b0;
    step();
    vld = 1'b1;
    repeat (3) step();
    check("t4b_pre", {st, pass}, {2'd1, 1'b0});
    step();
    check("t4b_halt", {st, pass}, {2'd2, 1'b1});
    check("t4b_hpc", halt_pc, 32'h80);
    check("t4b_ret", retired, 8);

    // 5: sync clear, then async reset mid-run
    do_reset();
    vld = 1'b1;
    for (int k = 0; k < 10; k++) begin
      pc = 32'(4 * k);
      step();
    end
    check("t5_pre", retired, 10);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("t5_clr_st", st, 0);
    check("t5_clr_cnt", {cycles, retired}, 0);
    check("t5_clr_out", {pass, fail, svld, halt_pc}, 0);
    for (int k = 0; k < 5; k++) begin
      pc = 32'(100 + 4 * k);
      step();
    end
    check("t5_restart", {st, retired[7:0], cycles[7:0]}, {2'd1, 8'd5, 8'd5});
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_arst_st", st, 0);
    check("t5_arst_cnt", {cycles, retired}, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pc = 32'(200 + 4 * k);
      step();
    end
    check("t5_arst_run", {st, retired[7:0]}, {2'd1, 8'd3});

    // 6: CNT_W=4 saturation
    do_reset();
    vld = 1'b1;
    for (int k = 0; k < 20; k++) begin
      pc = 32'(8 * k);
      step();
    end
    check("t6_ret", retired4, 15);
    check("t6_cyc", cycles4, 15);
    check("t6_st", st4, 1);
    check("t6_pf", {pass4, fail4}, 0);
    check("t6_wide", retired, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
